// File: rtl/dff_response_checker.sv
// Response checker for the set/reset DFF under test: runs golden sync/async R/S flop models,
// compares the DUT outputs over a fixed window and reports pass/fail with error statistics.
//
// state | meaning
// IDLE  | waiting for start, results from reset
// WARM  | models tracking, no compare for SETTLE cycles
// CHECK | compare each edge, window index 0..WINDOW-1
// DONE  | results held, start begins a new run
module dff_response_checker #(
  parameter int SETTLE = 2,
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             set_n,
  input  logic             reset_n,
  input  logic             d,
  input  logic             q_sync,
  input  logic             q_async,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_sync,
  output logic             err_async,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err
);

  localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_CHECK, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] idx;
  logic             ms, ma;
  logic             exp_async;
  logic             mis_sync, mis_async, mismatch;
  logic             tc;

  assign tc        = (tmr == '0);
  assign exp_async = !reset_n ? 1'b0 : (!set_n ? 1'b1 : ma);
  // case inequality so X/Z on the DUT outputs counts as a mismatch in simulation
  assign mis_sync  = (q_sync !== ms);
  assign mis_async = (q_async !== exp_async);
  assign mismatch  = mis_sync | mis_async;

  assign busy = (state == S_WARM) || (state == S_CHECK);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (SETTLE == 0) ? S_CHECK : S_WARM;
      S_WARM:         if (tc) state_nxt = S_CHECK;
      S_CHECK:        if (tc) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms        <= 1'b0;
      ma        <= 1'b0;
      tmr       <= '0;
      idx       <= '0;
      pass      <= 1'b0;
      err_sync  <= 1'b0;
      err_async <= 1'b0;
      err_cnt   <= '0;
      first_err <= '1;
    end else begin
      ms <= !reset_n ? 1'b0 : (!set_n ? 1'b1 : d);
      ma <= d;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            tmr       <= (SETTLE == 0) ? WINDOW_LD : SETTLE_LD;
            idx       <= '0;
            pass      <= 1'b0;
            err_sync  <= 1'b0;
            err_async <= 1'b0;
            err_cnt   <= '0;
            first_err <= '1;
          end
        end
        S_WARM: begin
          if (tc) tmr <= WINDOW_LD;
          else    tmr <= tmr - 1'b1;
        end
        S_CHECK: begin
          if (!tc) tmr <= tmr - 1'b1;
          idx <= idx + 1'b1;
          if (mis_sync)  err_sync  <= 1'b1;
          if (mis_async) err_async <= 1'b1;
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            // err_cnt saturates and never wraps, so zero means no earlier mismatch
            if (err_cnt == '0) first_err <= idx;
          end
          if (tc) pass <= !mismatch && (err_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: ideal flop model drives q inputs, with per-index inversion or
// forcing; expectations come from a table and from mismatch bookkeeping in the bench.
module tb_dff_response_checker;
  localparam int SETTLE  = 2;
  localparam int WINDOW  = 16;
  localparam int CNT_W   = 8;
  localparam int RUN_LEN = SETTLE + WINDOW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, set_n, reset_n, d, q_sync, q_async, q_sync2, q_async2;
  logic busy, done, pass, err_sync, err_async;
  logic [CNT_W-1:0] err_cnt, first_err;
  logic busy2, done2, pass2, err_sync2, err_async2;
  logic [2:0] err_cnt2, first_err2;

  dff_response_checker #(.SETTLE(SETTLE), .WINDOW(WINDOW), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .set_n(set_n), .reset_n(reset_n), .d(d),
    .q_sync(q_sync), .q_async(q_async), .busy(busy), .done(done), .pass(pass),
    .err_sync(err_sync), .err_async(err_async), .err_cnt(err_cnt), .first_err(first_err)
  );

  dff_response_checker #(.SETTLE(2), .WINDOW(7), .CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .start(start), .set_n(set_n), .reset_n(reset_n), .d(d),
    .q_sync(q_sync2), .q_async(q_async2), .busy(busy2), .done(done2), .pass(pass2),
    .err_sync(err_sync2), .err_async(err_async2), .err_cnt(err_cnt2), .first_err(first_err2)
  );

  typedef struct {
    logic [15:0] inv_s;
    logic [15:0] inv_a;
    bit          es;
    bit          ea;
    int          cnt;
    int          first;
  } vec_t;

  vec_t tab [6];

  int checks = 0;
  int errors = 0;
  bit prev_s = 1'b0;
  bit prev_d = 1'b0;

  bit       ovr_en  [0:31];
  bit [2:0] ovr_val [0:31];
  bit [1:0] qs_mode_a [0:15];
  bit [1:0] qa_mode_a [0:15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit apply_mode(input bit v, input bit [1:0] m);
    case (m)
      2'd1:    return ~v;
      2'd2:    return 1'b0;
      2'd3:    return 1'b1;
      default: return v;
    endcase
  endfunction

  task automatic clear_ovr();
    for (int i = 0; i < 32; i++) begin ovr_en[i] = 1'b0; ovr_val[i] = 3'b000; end
    for (int i = 0; i < 16; i++) begin qs_mode_a[i] = 2'd0; qa_mode_a[i] = 2'd0; end
  endtask

  // Drive one cycle at the negedge, let the edge happen, return at the next negedge.
  task automatic drive(input bit rst, input bit st, input bit sn_i, input bit rn_i, input bit d_i,
                       input bit [1:0] qs_m, input bit [1:0] qa_m,
                       output bit mis_s, output bit mis_a);
    bit is, ia, qs, qa;
    is = prev_s;
    ia = !rn_i ? 1'b0 : (!sn_i ? 1'b1 : prev_d);
    qs = apply_mode(is, qs_m);
    qa = apply_mode(ia, qa_m);
    mis_s = (qs != is);
    mis_a = (qa != ia);
    reset = rst; start = st; set_n = sn_i; reset_n = rn_i; d = d_i;
    q_sync = qs; q_async = qa; q_sync2 = ~is; q_async2 = ia;
    @(posedge clk);
    if (rst) begin
      prev_s = 1'b0;
      prev_d = 1'b0;
    end else begin
      prev_s = rn_i ? (sn_i ? d_i : 1'b1) : 1'b0;
      prev_d = d_i;
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] inv_s, input logic [15:0] inv_a, input int extra_k,
                     input int abort_k, input bit use_tab, input vec_t tv);
    int cnt, first;
    bit es, ea;
    cnt = 0; first = 255; es = 1'b0; ea = 1'b0;
    for (int k = 0; k < RUN_LEN; k++) begin
      bit sn, rn, dd, m_s, m_a;
      bit [1:0] qm_s, qm_a;
      int idx;
      if (ovr_en[k]) {sn, rn, dd} = ovr_val[k];
      else begin
        sn = ($urandom_range(3) != 0);
        rn = ($urandom_range(3) != 0);
        dd = $urandom_range(1);
      end
      idx = k - (SETTLE + 1);
      qm_s = 2'd0; qm_a = 2'd0;
      if (idx >= 0 && idx < WINDOW) begin
        qm_s = inv_s[idx] ? 2'd1 : qs_mode_a[idx];
        qm_a = inv_a[idx] ? 2'd1 : qa_mode_a[idx];
      end
      drive(k == abort_k, (k == 0) || (k == extra_k), sn, rn, dd, qm_s, qm_a, m_s, m_a);
      if (k == abort_k) begin
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err_cnt", err_cnt, 0);
        chk("abort_err_sync", err_sync, 0);
        chk("abort_first_err", first_err, 255);
        clear_ovr();
        return;
      end
      if (idx >= 0 && idx < WINDOW) begin
        if (m_s) es = 1'b1;
        if (m_a) ea = 1'b1;
        if (m_s || m_a) begin
          if (cnt == 0) first = idx;
          cnt++;
        end
      end
      if (k == 1) chk("warm_busy", busy, 1);
      if (k == RUN_LEN - 2) begin
        chk("pre_done", done, 0);
        chk("pre_busy", busy, 1);
      end
      if (k == 8) chk("small_pre_done", done2, 0);
      if (k == 9) begin
        chk("small_done", done2, 1);
        chk("small_err_cnt", err_cnt2, 7);
        chk("small_first_err", first_err2, 0);
        chk("small_err_sync", err_sync2, 1);
        chk("small_err_async", err_async2, 0);
        chk("small_pass", pass2, 0);
      end
    end
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("pass", pass, (cnt == 0) ? 1 : 0);
    chk("err_sync", err_sync, es);
    chk("err_async", err_async, ea);
    chk("err_cnt", err_cnt, cnt);
    chk("first_err", first_err, first);
    if (use_tab) begin
      chk("tab_pass", pass, (tv.cnt == 0) ? 1 : 0);
      chk("tab_err_sync", err_sync, tv.es);
      chk("tab_err_async", err_async, tv.ea);
      chk("tab_err_cnt", err_cnt, tv.cnt);
      chk("tab_first_err", first_err, tv.first);
    end
    clear_ovr();
  endtask

  task automatic idle_tick();
    bit ms_, ma_;
    drive(1'b0, 1'b0, $urandom_range(1), $urandom_range(1), $urandom_range(1), 2'd0, 2'd0, ms_, ma_);
  endtask

  initial begin
    bit ms_, ma_;
    vec_t none;
    tab[0] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 0, 255};
    tab[1] = '{16'h0008, 16'h0000, 1'b1, 1'b0, 1, 3};
    tab[2] = '{16'h0000, 16'h8001, 1'b0, 1'b1, 2, 0};
    tab[3] = '{16'h0020, 16'h0020, 1'b1, 1'b1, 1, 5};
    tab[4] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16, 0};
    tab[5] = '{16'h00F0, 16'h0F00, 1'b1, 1'b1, 8, 4};
    none = tab[0];
    clear_ovr();

    reset = 1'b1; start = 1'b0; set_n = 1'b1; reset_n = 1'b1; d = 1'b0;
    q_sync = 1'b0; q_async = 1'b0; q_sync2 = 1'b1; q_async2 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, ms_, ma_);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_sync", err_sync, 0);
    chk("rst_err_async", err_async, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_err", first_err, 255);
    idle_tick();
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      run(tab[i].inv_s, tab[i].inv_a, -1, -1, 1'b1, tab[i]);
      idle_tick();
      chk("done_hold", done, 1);
    end

    // q_sync held low at idx 3 while the preceding edge saw set_n=0, reset_n=1
    ovr_en[5] = 1'b1; ovr_val[5] = {1'b0, 1'b1, 1'($urandom_range(1))};
    qs_mode_a[3] = 2'd2;
    run(16'h0, 16'h0, -1, -1, 1'b1, '{16'h0, 16'h0, 1'b1, 1'b0, 1, 3});

    // reset_n and set_n both low at idx 6 with q_async=1: reset wins, mismatch
    ovr_en[9] = 1'b1; ovr_val[9] = 3'b000;
    qa_mode_a[6] = 2'd3;
    run(16'h0, 16'h0, -1, -1, 1'b1, '{16'h0, 16'h0, 1'b0, 1'b1, 1, 6});

    run(16'h0002, 16'h0, -1, 8, 1'b0, none);
    run(16'h0, 16'h0, -1, -1, 1'b1, none);

    run(16'h0, 16'h0, 8, -1, 1'b1, none);

    for (int r = 0; r < 8; r++) begin
      logic [15:0] ms_rand, ma_rand;
      ms_rand = 16'($urandom & $urandom & $urandom);
      ma_rand = 16'($urandom & $urandom & $urandom);
      run(ms_rand, ma_rand, -1, -1, 1'b0, none);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
